ch_cfg_ctrl: RTL and testbench
==============================

# ch_cfg_ctrl

Parametrised successor to the channel-configuration FSM pair. It scans a register-file channel mask on a CPU configuration interrupt, fetches each newly enabled channel's priority and transfer size, and presents them to the arbiter. It then tracks completions, writes a done-status bitmap back through a write handshake, and raises per-channel and end-of-job interrupts. New behaviour: a parametrised channel count and field widths, incremental rescan while channels are running, and queuing of completions while a write-back is stalled.

## Interface
- NUM_CH, 32, channel count; 2..REGFILE_DATA_WIDTH
- CH_ID_W, $clog2(NUM_CH), channel-id width
- PRIO_W, 4, priority field width (word0[PRIO_W-1:0])
- SIZE_W, 32, transfer-size width (word1[SIZE_W-1:0]); ≤ REGFILE_DATA_WIDTH
- REGFILE_ADDR_WIDTH, 8; REGFILE_DATA_WIDTH, 32
- MASK_ADDR 'h00, DONE_ADDR 'h04, CH_BASE_ADDR 'h10, CH_STRIDE 8; channel n word0 at CH_BASE_ADDR+n*CH_STRIDE, word1 at +4
- AXI_aclk  in  1  clock; all logic on rising edge
- AXI_aresetn  in  1  reset; asynchronous, active-low
- CPU_interrupt_CFG  in  1  start/rescan request, level sampled per cycle
- CPU_interrupt_ch_done  out  1  one-cycle pulse per completed write-back
- CPU_interrupt_end  out  1  one-cycle pulse when the last active channel completes
- arbSample  out  1  one-cycle strobe; id/prio/size valid with it
- arbCurrentChannelSample  out  CH_ID_W;  arbChannelPriority  out  PRIO_W;  arbChannelTransferSize  out  SIZE_W
- arbitrate  out  1  one-cycle pulse after a scan that sampled ≥1 channel
- ch_id  in  CH_ID_W;  ch_done  in  1  completion strobe for ch_id
- chActiveChannels  out  NUM_CH  active bitmap
- chValidChannels  out  1  high in RUN only
- regFile_readEnable  out  1;  regFile_readAddr  out  REGFILE_ADDR_WIDTH;  regFile_readData  in  REGFILE_DATA_WIDTH (valid the cycle after readEnable)
- regFile_writeEnable  out  1;  regFile_writeAddr  out  REGFILE_ADDR_WIDTH;  regFile_writeData  out  REGFILE_DATA_WIDTH;  regFile_writeReady  in  1

## Operation
- Reset: all outputs 0, state IDLE; active, pending, done_status, scan_mask and rescan_req cleared. An in-flight write is abandoned.
- Main FSM: IDLE → RD_MASK → LATCH → {SCAN → RD_PRIO → RD_SIZE → SAMPLE}* → ARB → RUN.
- IDLE or RUN with CFG=1 → RD_MASK. RD_MASK drives readEnable with MASK_ADDR.
- LATCH: new = readData[NUM_CH-1:0] & ~active.
  - new==0: return to the origin state. Go to IDLE if active==0, otherwise RUN. No arbitrate.
  - new≠0: scan_mask=new, active|=new, then SCAN.
- SCAN: cur = lowest set bit of scan_mask; readEnable with word0 address.
- RD_PRIO: capture prio; readEnable with word1 address.
- RD_SIZE: capture size.
- SAMPLE: arbSample=1, clear cur from scan_mask. Go to SCAN if scan_mask≠0, else ARB.
- ARB: arbitrate=1, then RUN. If rescan_req is set, clear it and go to RD_MASK instead of RUN. arbitrate still pulses.
- CFG=1 in any state other than IDLE/RUN sets rescan_req. Requests are not lost.
- Completion: ch_done with active[ch_id]=1 sets pending[ch_id]. This applies in any state. ch_done for an inactive channel, or an already-pending one, is ignored.
- Write engine (W_IDLE, W_REQ), independent of the main FSM:
  - W_IDLE with pending≠0: pick lowest bit k, clear pending[k] and active[k], set done_status[k], go to W_REQ.
  - W_REQ: writeEnable=1, addr=DONE_ADDR, data=done_status zero-extended. Hold stable until writeReady=1, then pulse CPU_interrupt_ch_done and return to W_IDLE.
- End: at a write handshake, if the main FSM is in RUN and active==0, pending==0 and rescan_req==0, then CPU_interrupt_end pulses in the same cycle as ch_done. Main FSM goes to IDLE; done_status clears.
- Scan priority: when ch_done and a LATCH update of active occur in the same cycle, the completion clear applies after the OR. A completed channel is never re-armed by the same mask read.

## Timing
- CFG at edge n (IDLE): readEnable at n+1, LATCH at n+2, first arbSample at n+6.
- Each further channel adds 4 cycles. arbitrate comes 1 cycle after the last arbSample.
- chValidChannels rises on the cycle RUN is entered and falls on leaving RUN.
- ch_done at edge n with the write engine idle: writeEnable from n+2. ch_done interrupt is on the writeReady cycle.
- Outputs are registered. arbSample/arbitrate/interrupt pulses last exactly 1 cycle.

## Structure
- Package ch_cfg_pkg holds:
  - main_state_e and wr_state_e enums
  - default address constants
  - the lowest-set-bit function (NUM_CH-generic)
- Sub-module ch_cfg_done_writer holds the pending bitmap, the write engine and done_status. Main FSM and scan stay in ch_cfg_ctrl.

## Test plan
- Mask 0x8, ch3 prio 5 size 0x100 → one arbSample (3,5,0x100), arbitrate, active=0x8. ch_done id 3 → write DONE_ADDR 0x8, ch_done and end interrupts in the same cycle.
- Mask 0x0 → returns to IDLE, no arbSample, no arbitrate.
- Mask 0x5 running, writeReady held low 6 cycles, ch_done id 0 then id 2 on consecutive cycles → writes 0x1 then 0x5, two ch_done pulses, end on the second.
- In RUN with active=0x1, mask rewritten to 0x3 and CFG pulsed → only ch1 sampled. Active becomes 0x3, arbitrate pulses.
- CFG during SCAN → rescan_req; ARB goes to RD_MASK. ch_done id 7 while active[7]=0 → no write.
- Reset asserted mid-W_REQ → all outputs 0 within the reset assertion, no interrupt. Next CFG scans from active=0.

Source files
------------

// File: rtl/ch_cfg_pkg.sv
// Shared types, default register map and helpers for the channel-configuration controller.
package ch_cfg_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StRdMask,
    StLatch,
    StScan,
    StRdPrio,
    StRdSize,
    StSample,
    StArb,
    StRun
  } main_state_e;

  typedef enum logic {
    WIdle,
    WReq
  } wr_state_e;

  localparam int unsigned DEF_MASK_ADDR    = 32'h00;
  localparam int unsigned DEF_DONE_ADDR    = 32'h04;
  localparam int unsigned DEF_CH_BASE_ADDR = 32'h10;
  localparam int unsigned DEF_CH_STRIDE    = 8;

  // Widest channel bitmap the helper accepts; narrower maps are zero-extended by the caller.
  localparam int unsigned MAX_CH = 64;

  function automatic int unsigned lowest_set(input logic [MAX_CH-1:0] vec);
    lowest_set = 0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = unsigned'(i);
    end
  endfunction

endpackage

// File: rtl/ch_cfg_done_writer.sv
// Completion tracker: queues channel completions and writes the done-status bitmap back,
// one handshake per completed channel, raising the per-channel and end-of-job interrupts.
module ch_cfg_done_writer
  import ch_cfg_pkg::*;
#(
  parameter int unsigned NUM_CH    = 32,
  parameter int unsigned CH_ID_W   = $clog2(NUM_CH),
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DONE_ADDR = DEF_DONE_ADDR
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_CH-1:0]  active_i,
  input  logic               ch_done_i,
  input  logic [CH_ID_W-1:0] ch_id_i,
  input  logic               run_quiet_i,
  input  logic               write_ready_i,
  output logic [NUM_CH-1:0]  active_clr_o,
  output logic               end_evt_o,
  output logic               write_enable_o,
  output logic [ADDR_W-1:0]  write_addr_o,
  output logic [DATA_W-1:0]  write_data_o,
  output logic               irq_ch_done_o,
  output logic               irq_end_o
);

  wr_state_e         state_q, state_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] pick;
  logic              done_hit;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              irq_chd_q, irq_chd_d;
  logic              irq_end_q;

  // Completions for inactive or already-queued channels are dropped.
  assign done_hit = ch_done_i && (32'(ch_id_i) < NUM_CH) && active_i[ch_id_i]
                    && !pending_q[ch_id_i];

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = done_q;
    pick      = '0;
    irq_chd_d = 1'b0;
    end_evt_o = 1'b0;
    if (done_hit) pending_d[ch_id_i] = 1'b1;
    unique case (state_q)
      WIdle: begin
        if (pending_q != '0) begin
          pick      = NUM_CH'(1) << lowest_set(MAX_CH'(pending_q));
          pending_d = pending_d & ~pick;
          done_d    = done_q | pick;
          state_d   = WReq;
        end
      end
      WReq: begin
        if (write_ready_i) begin
          state_d   = WIdle;
          irq_chd_d = 1'b1;
          if (run_quiet_i && pending_q == '0) begin
            end_evt_o = 1'b1;
            done_d    = '0;
          end
        end
      end
      default: state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= WIdle;
      pending_q <= '0;
      done_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      irq_chd_q <= 1'b0;
      irq_end_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      we_q      <= (state_d == WReq);
      addr_q    <= (state_d == WReq) ? ADDR_W'(DONE_ADDR) : '0;
      data_q    <= (state_d == WReq) ? DATA_W'(done_d) : '0;
      irq_chd_q <= irq_chd_d;
      irq_end_q <= end_evt_o;
    end
  end

  assign active_clr_o   = pick;
  assign write_enable_o = we_q;
  assign write_addr_o   = addr_q;
  assign write_data_o   = data_q;
  assign irq_ch_done_o  = irq_chd_q;
  assign irq_end_o      = irq_end_q;

endmodule

// File: rtl/ch_cfg_ctrl.sv
// Channel-configuration controller: scans the channel mask on a CFG request, fetches each
// newly enabled channel's priority and size for the arbiter, and hands completions to the writer.
module ch_cfg_ctrl
  import ch_cfg_pkg::*;
#(
  parameter int unsigned NUM_CH             = 32,
  parameter int unsigned CH_ID_W            = $clog2(NUM_CH),
  parameter int unsigned PRIO_W             = 4,
  parameter int unsigned SIZE_W             = 32,
  parameter int unsigned REGFILE_ADDR_WIDTH = 8,
  parameter int unsigned REGFILE_DATA_WIDTH = 32,
  parameter int unsigned MASK_ADDR          = DEF_MASK_ADDR,
  parameter int unsigned DONE_ADDR          = DEF_DONE_ADDR,
  parameter int unsigned CH_BASE_ADDR       = DEF_CH_BASE_ADDR,
  parameter int unsigned CH_STRIDE          = DEF_CH_STRIDE
) (
  input  logic                          AXI_aclk,
  input  logic                          AXI_aresetn,
  input  logic                          CPU_interrupt_CFG,
  output logic                          CPU_interrupt_ch_done,
  output logic                          CPU_interrupt_end,
  output logic                          arbSample,
  output logic [CH_ID_W-1:0]            arbCurrentChannelSample,
  output logic [PRIO_W-1:0]             arbChannelPriority,
  output logic [SIZE_W-1:0]             arbChannelTransferSize,
  output logic                          arbitrate,
  input  logic [CH_ID_W-1:0]            ch_id,
  input  logic                          ch_done,
  output logic [NUM_CH-1:0]             chActiveChannels,
  output logic                          chValidChannels,
  output logic                          regFile_readEnable,
  output logic [REGFILE_ADDR_WIDTH-1:0] regFile_readAddr,
  input  logic [REGFILE_DATA_WIDTH-1:0] regFile_readData,
  output logic                          regFile_writeEnable,
  output logic [REGFILE_ADDR_WIDTH-1:0] regFile_writeAddr,
  output logic [REGFILE_DATA_WIDTH-1:0] regFile_writeData,
  input  logic                          regFile_writeReady
);

  localparam int unsigned AW = REGFILE_ADDR_WIDTH;

  main_state_e       state_q, state_d;
  logic [NUM_CH-1:0] active_q, active_d, active_clr, set_mask;
  logic [NUM_CH-1:0] scan_mask_q, scan_mask_d, new_mask, scan_rem;
  logic [CH_ID_W-1:0] cur_q, cur_d;
  logic [PRIO_W-1:0] prio_q, prio_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic              rescan_q, rescan_d;
  logic              run_quiet, end_evt;
  logic              rd_en_q, rd_en_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic              arb_sample_q, arbitrate_q, ch_valid_q;

  assign new_mask  = regFile_readData[NUM_CH-1:0] & ~active_q;
  assign scan_rem  = scan_mask_q & ~(NUM_CH'(1) << cur_q);
  assign run_quiet = (state_q == StRun) && (active_q == '0) && !rescan_q;
  // Writer clears apply after the LATCH OR, so a completing channel is never re-armed.
  assign active_d  = (active_q | set_mask) & ~active_clr;

  always_comb begin
    state_d     = state_q;
    scan_mask_d = scan_mask_q;
    cur_d       = cur_q;
    prio_d      = prio_q;
    size_d      = size_q;
    set_mask    = '0;
    unique case (state_q)
      StIdle:   if (CPU_interrupt_CFG || rescan_q) state_d = StRdMask;
      StRdMask: state_d = StLatch;
      StLatch: begin
        if (new_mask == '0) begin
          state_d = (active_q == '0) ? StIdle : StRun;
        end else begin
          scan_mask_d = new_mask;
          set_mask    = new_mask;
          cur_d       = CH_ID_W'(lowest_set(MAX_CH'(new_mask)));
          state_d     = StScan;
        end
      end
      StScan:   state_d = StRdPrio;
      StRdPrio: begin
        prio_d  = regFile_readData[PRIO_W-1:0];
        state_d = StRdSize;
      end
      StRdSize: begin
        size_d  = regFile_readData[SIZE_W-1:0];
        state_d = StSample;
      end
      StSample: begin
        scan_mask_d = scan_rem;
        if (scan_rem != '0) begin
          cur_d   = CH_ID_W'(lowest_set(MAX_CH'(scan_rem)));
          state_d = StScan;
        end else begin
          state_d = StArb;
        end
      end
      StArb:    state_d = (rescan_q || CPU_interrupt_CFG) ? StRdMask : StRun;
      StRun: begin
        // A CFG arriving with the final handshake still starts a fresh scan.
        if (end_evt) state_d = CPU_interrupt_CFG ? StRdMask : StIdle;
        else if (CPU_interrupt_CFG || rescan_q) state_d = StRdMask;
      end
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    rescan_d = rescan_q;
    if (CPU_interrupt_CFG && !(state_q inside {StIdle, StRun})) rescan_d = 1'b1;
    if (state_d == StRdMask) rescan_d = 1'b0;
  end

  always_comb begin
    rd_en_d   = state_d inside {StRdMask, StScan, StRdPrio};
    rd_addr_d = '0;
    case (state_d)
      StRdMask: rd_addr_d = AW'(MASK_ADDR);
      StScan:   rd_addr_d = AW'(CH_BASE_ADDR + 32'(cur_d) * CH_STRIDE);
      StRdPrio: rd_addr_d = AW'(CH_BASE_ADDR + 32'(cur_d) * CH_STRIDE + 32'd4);
      default:  rd_addr_d = '0;
    endcase
  end

  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) begin
      state_q      <= StIdle;
      active_q     <= '0;
      scan_mask_q  <= '0;
      cur_q        <= '0;
      prio_q       <= '0;
      size_q       <= '0;
      rescan_q     <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      arb_sample_q <= 1'b0;
      arbitrate_q  <= 1'b0;
      ch_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      scan_mask_q  <= scan_mask_d;
      cur_q        <= cur_d;
      prio_q       <= prio_d;
      size_q       <= size_d;
      rescan_q     <= rescan_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      arb_sample_q <= (state_d == StSample);
      arbitrate_q  <= (state_d == StArb);
      ch_valid_q   <= (state_d == StRun);
    end
  end

  ch_cfg_done_writer #(
    .NUM_CH    (NUM_CH),
    .CH_ID_W   (CH_ID_W),
    .ADDR_W    (REGFILE_ADDR_WIDTH),
    .DATA_W    (REGFILE_DATA_WIDTH),
    .DONE_ADDR (DONE_ADDR)
  ) u_done_writer (
    .clk_i          (AXI_aclk),
    .rst_ni         (AXI_aresetn),
    .active_i       (active_q),
    .ch_done_i      (ch_done),
    .ch_id_i        (ch_id),
    .run_quiet_i    (run_quiet),
    .write_ready_i  (regFile_writeReady),
    .active_clr_o   (active_clr),
    .end_evt_o      (end_evt),
    .write_enable_o (regFile_writeEnable),
    .write_addr_o   (regFile_writeAddr),
    .write_data_o   (regFile_writeData),
    .irq_ch_done_o  (CPU_interrupt_ch_done),
    .irq_end_o      (CPU_interrupt_end)
  );

  assign arbSample               = arb_sample_q;
  assign arbCurrentChannelSample = cur_q;
  assign arbChannelPriority      = prio_q;
  assign arbChannelTransferSize  = size_q;
  assign arbitrate               = arbitrate_q;
  assign chActiveChannels        = active_q;
  assign chValidChannels         = ch_valid_q;
  assign regFile_readEnable      = rd_en_q;
  assign regFile_readAddr        = rd_addr_q;

endmodule

// File: tb/tb_ch_cfg_ctrl.sv
// Scoreboard bench for ch_cfg_ctrl: register-file model, arbiter/write monitors, scenario tasks.
module tb_ch_cfg_ctrl;
  localparam logic [7:0] MASK_A = 8'h00;
  localparam logic [7:0] DONE_A = 8'h04;

  logic        clk = 1'b0, rstn = 1'b0, cfg = 1'b0, ch_done = 1'b0, wready = 1'b1;
  logic [4:0]  ch_id = '0;
  logic        irq_chd, irq_end, arb_s, arbt, valid, rd_en, we;
  logic [4:0]  arb_id;
  logic [3:0]  arb_prio;
  logic [31:0] arb_size, active, rdata, wd;
  logic [7:0]  rd_addr, wa;
  logic [31:0] mem [256];

  ch_cfg_ctrl dut (
    .AXI_aclk(clk), .AXI_aresetn(rstn), .CPU_interrupt_CFG(cfg),
    .CPU_interrupt_ch_done(irq_chd), .CPU_interrupt_end(irq_end),
    .arbSample(arb_s), .arbCurrentChannelSample(arb_id), .arbChannelPriority(arb_prio),
    .arbChannelTransferSize(arb_size), .arbitrate(arbt), .ch_id(ch_id), .ch_done(ch_done),
    .chActiveChannels(active), .chValidChannels(valid),
    .regFile_readEnable(rd_en), .regFile_readAddr(rd_addr), .regFile_readData(rdata),
    .regFile_writeEnable(we), .regFile_writeAddr(wa), .regFile_writeData(wd),
    .regFile_writeReady(wready)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [4:0] id; logic [3:0] prio; logic [31:0] size;} arb_t;
  typedef struct packed {logic [7:0] addr; logic [31:0] data;} wr_t;
  arb_t exp_arb[$], obs_arb[$];
  wr_t  exp_wr[$], obs_wr[$];

  int n_checks = 0, n_pass = 0, cyc = 0;
  int arbt_cnt = 0, mask_rd_cnt = 0, chd_cnt = 0, end_cnt = 0, end_alone = 0;
  int last_samp_cyc = 0, last_arbt_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rdata <= mem[rd_addr];
  end

  always @(negedge clk) begin
    if (arb_s) begin
      obs_arb.push_back({arb_id, arb_prio, arb_size});
      last_samp_cyc <= cyc;
    end
    if (arbt) begin
      arbt_cnt <= arbt_cnt + 1;
      last_arbt_cyc <= cyc;
    end
    if (rd_en && rd_addr == MASK_A) mask_rd_cnt <= mask_rd_cnt + 1;
    if (we && wready) obs_wr.push_back({wa, wd});
    if (irq_chd) chd_cnt <= chd_cnt + 1;
    if (irq_end) begin
      end_cnt <= end_cnt + 1;
      if (!irq_chd) end_alone <= end_alone + 1;
    end
  end

  function automatic arb_t mk_arb(input int id, input int prio, input logic [31:0] size);
    mk_arb = {5'(id), 4'(prio), size};
  endfunction

  function automatic wr_t mk_wr(input logic [31:0] data);
    mk_wr = {DONE_A, data};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_cfg();
    cfg = 1'b1;
    tick(1);
    cfg = 1'b0;
  endtask

  task automatic pulse_done(input int id);
    ch_id = 5'(id);
    ch_done = 1'b1;
    tick(1);
    ch_done = 1'b0;
  endtask

  task automatic set_ch(input int id, input int prio, input logic [31:0] size);
    mem[8'h10 + id * 8]     = 32'(prio);
    mem[8'h10 + id * 8 + 4] = size;
  endtask

  task automatic wait_run(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (valid) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic wait_end(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (end_cnt > base) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    tick(1);
  endtask

  task automatic test_reset();
    n_checks++;
    if ({rd_en, we, arb_s, arbt, valid, irq_chd, irq_end} !== 7'b0)
      $display("FAIL reset_strobes: got %b want 0", {rd_en, we, arb_s, arbt, valid, irq_chd, irq_end});
    else n_pass++;
    n_checks++;
    if (active !== 32'h0) $display("FAIL reset_active: got %h want 0", active);
    else n_pass++;
    n_checks++;
    if ({rd_addr, wa, wd} !== 48'h0) $display("FAIL reset_bus: got %h want 0", {rd_addr, wa, wd});
    else n_pass++;
  endtask

  task automatic test_single();
    bit ok;
    int a0, c0, e0;
    mem[MASK_A] = 32'h8;
    set_ch(3, 5, 32'h100);
    exp_arb.push_back(mk_arb(3, 5, 32'h100));
    a0 = arbt_cnt;
    pulse_cfg();
    wait_run(40, ok);
    n_checks++;
    if (!ok) $display("FAIL single_run_timeout: got no RUN want RUN"); else n_pass++;
    while (exp_arb.size() != 0) begin
      arb_t w = exp_arb.pop_front();
      n_checks++;
      if (obs_arb.size() == 0) $display("FAIL single_sample: got none want %h", w);
      else begin
        arb_t g = obs_arb.pop_front();
        if (g !== w) $display("FAIL single_sample: got %h want %h", g, w); else n_pass++;
      end
    end
    n_checks++;
    if (arbt_cnt - a0 != 1) $display("FAIL single_arbitrate: got %0d want 1", arbt_cnt - a0);
    else n_pass++;
    n_checks++;
    if (last_arbt_cyc - last_samp_cyc != 1)
      $display("FAIL single_arb_gap: got %0d want 1", last_arbt_cyc - last_samp_cyc);
    else n_pass++;
    n_checks++;
    if (active !== 32'h8) $display("FAIL single_active: got %h want 8", active); else n_pass++;
    c0 = chd_cnt;
    e0 = end_cnt;
    exp_wr.push_back(mk_wr(32'h8));
    pulse_done(3);
    wait_end(e0, 40, ok);
    n_checks++;
    if (!ok) $display("FAIL single_end_timeout: got no end want end"); else n_pass++;
    while (exp_wr.size() != 0) begin
      wr_t w = exp_wr.pop_front();
      n_checks++;
      if (obs_wr.size() == 0) $display("FAIL single_write: got none want %h", w);
      else begin
        wr_t g = obs_wr.pop_front();
        if (g !== w) $display("FAIL single_write: got %h want %h", g, w); else n_pass++;
      end
    end
    n_checks++;
    if (chd_cnt - c0 != 1 || end_alone != 0)
      $display("FAIL single_irqs: got chd=%0d alone=%0d want chd=1 alone=0", chd_cnt - c0, end_alone);
    else n_pass++;
    n_checks++;
    if (valid !== 1'b0 || active !== 32'h0)
      $display("FAIL single_idle: got valid=%b active=%h want 0 0", valid, active);
    else n_pass++;
  endtask

  task automatic test_empty_mask();
    int a0, m0;
    mem[MASK_A] = 32'h0;
    a0 = arbt_cnt;
    m0 = mask_rd_cnt;
    pulse_cfg();
    tick(12);
    n_checks++;
    if (obs_arb.size() != 0 || arbt_cnt != a0)
      $display("FAIL empty_no_arb: got samples=%0d arbs=%0d want 0 0", obs_arb.size(), arbt_cnt - a0);
    else n_pass++;
    n_checks++;
    if (mask_rd_cnt - m0 != 1 || valid !== 1'b0)
      $display("FAIL empty_idle: got reads=%0d valid=%b want 1 0", mask_rd_cnt - m0, valid);
    else n_pass++;
  endtask

  task automatic test_stall();
    bit ok;
    int c0, e0;
    mem[MASK_A] = 32'h5;
    set_ch(0, 2, 32'h40);
    set_ch(2, 9, 32'h1234);
    exp_arb.push_back(mk_arb(0, 2, 32'h40));
    exp_arb.push_back(mk_arb(2, 9, 32'h1234));
    pulse_cfg();
    wait_run(60, ok);
    n_checks++;
    if (!ok) $display("FAIL stall_run_timeout: got no RUN want RUN"); else n_pass++;
    while (exp_arb.size() != 0) begin
      arb_t w = exp_arb.pop_front();
      n_checks++;
      if (obs_arb.size() == 0) $display("FAIL stall_sample: got none want %h", w);
      else begin
        arb_t g = obs_arb.pop_front();
        if (g !== w) $display("FAIL stall_sample: got %h want %h", g, w); else n_pass++;
      end
    end
    c0 = chd_cnt;
    e0 = end_cnt;
    wready = 1'b0;
    exp_wr.push_back(mk_wr(32'h1));
    exp_wr.push_back(mk_wr(32'h5));
    pulse_done(0);
    pulse_done(2);
    tick(2);
    n_checks++;
    if ({we, wa, wd} !== {1'b1, DONE_A, 32'h1})
      $display("FAIL stall_hold: got %b %h %h want 1 04 1", we, wa, wd);
    else n_pass++;
    tick(4);
    n_checks++;
    if ({we, wd} !== {1'b1, 32'h1} || chd_cnt != c0)
      $display("FAIL stall_stable: got we=%b data=%h chd=%0d want 1 1 0", we, wd, chd_cnt - c0);
    else n_pass++;
    wready = 1'b1;
    wait_end(e0, 40, ok);
    n_checks++;
    if (!ok) $display("FAIL stall_end_timeout: got no end want end"); else n_pass++;
    while (exp_wr.size() != 0) begin
      wr_t w = exp_wr.pop_front();
      n_checks++;
      if (obs_wr.size() == 0) $display("FAIL stall_write: got none want %h", w);
      else begin
        wr_t g = obs_wr.pop_front();
        if (g !== w) $display("FAIL stall_write: got %h want %h", g, w); else n_pass++;
      end
    end
    n_checks++;
    if (chd_cnt - c0 != 2 || end_cnt - e0 != 1 || end_alone != 0)
      $display("FAIL stall_irqs: got chd=%0d end=%0d alone=%0d want 2 1 0",
               chd_cnt - c0, end_cnt - e0, end_alone);
    else n_pass++;
  endtask

  task automatic test_incremental();
    bit ok;
    int a0, e0;
    mem[MASK_A] = 32'h1;
    set_ch(0, 1, 32'h10);
    set_ch(1, 7, 32'h55);
    pulse_cfg();
    wait_run(40, ok);
    obs_arb.delete();
    mem[MASK_A] = 32'h3;
    exp_arb.push_back(mk_arb(1, 7, 32'h55));
    a0 = arbt_cnt;
    pulse_cfg();
    wait_run(40, ok);
    n_checks++;
    if (!ok) $display("FAIL incr_run_timeout: got no RUN want RUN"); else n_pass++;
    while (exp_arb.size() != 0) begin
      arb_t w = exp_arb.pop_front();
      n_checks++;
      if (obs_arb.size() == 0) $display("FAIL incr_sample: got none want %h", w);
      else begin
        arb_t g = obs_arb.pop_front();
        if (g !== w) $display("FAIL incr_sample: got %h want %h", g, w); else n_pass++;
      end
    end
    n_checks++;
    if (obs_arb.size() != 0 || arbt_cnt - a0 != 1 || active !== 32'h3)
      $display("FAIL incr_state: got extra=%0d arbs=%0d active=%h want 0 1 3",
               obs_arb.size(), arbt_cnt - a0, active);
    else n_pass++;
    e0 = end_cnt;
    exp_wr.push_back(mk_wr(32'h1));
    exp_wr.push_back(mk_wr(32'h3));
    pulse_done(0);
    pulse_done(1);
    wait_end(e0, 40, ok);
    while (exp_wr.size() != 0) begin
      wr_t w = exp_wr.pop_front();
      n_checks++;
      if (obs_wr.size() == 0) $display("FAIL incr_write: got none want %h", w);
      else begin
        wr_t g = obs_wr.pop_front();
        if (g !== w) $display("FAIL incr_write: got %h want %h", g, w); else n_pass++;
      end
    end
  endtask

  task automatic test_rescan();
    bit ok;
    int a0, m0, c0, e0;
    mem[MASK_A] = 32'h3;
    set_ch(0, 3, 32'h20);
    set_ch(1, 4, 32'h30);
    exp_arb.push_back(mk_arb(0, 3, 32'h20));
    exp_arb.push_back(mk_arb(1, 4, 32'h30));
    a0 = arbt_cnt;
    m0 = mask_rd_cnt;
    pulse_cfg();
    tick(2);
    pulse_cfg();
    wait_run(60, ok);
    n_checks++;
    if (!ok) $display("FAIL rescan_run_timeout: got no RUN want RUN"); else n_pass++;
    while (exp_arb.size() != 0) begin
      arb_t w = exp_arb.pop_front();
      n_checks++;
      if (obs_arb.size() == 0) $display("FAIL rescan_sample: got none want %h", w);
      else begin
        arb_t g = obs_arb.pop_front();
        if (g !== w) $display("FAIL rescan_sample: got %h want %h", g, w); else n_pass++;
      end
    end
    n_checks++;
    if (mask_rd_cnt - m0 != 2 || arbt_cnt - a0 != 1 || active !== 32'h3)
      $display("FAIL rescan_state: got reads=%0d arbs=%0d active=%h want 2 1 3",
               mask_rd_cnt - m0, arbt_cnt - a0, active);
    else n_pass++;
    c0 = chd_cnt;
    pulse_done(7);
    tick(8);
    n_checks++;
    if (obs_wr.size() != 0 || chd_cnt != c0)
      $display("FAIL rescan_inactive_done: got writes=%0d chd=%0d want 0 0", obs_wr.size(), chd_cnt - c0);
    else n_pass++;
    e0 = end_cnt;
    exp_wr.push_back(mk_wr(32'h1));
    exp_wr.push_back(mk_wr(32'h3));
    pulse_done(0);
    pulse_done(1);
    wait_end(e0, 40, ok);
    n_checks++;
    if (!ok) $display("FAIL rescan_end_timeout: got no end want end"); else n_pass++;
    while (exp_wr.size() != 0) begin
      wr_t w = exp_wr.pop_front();
      n_checks++;
      if (obs_wr.size() == 0) $display("FAIL rescan_write: got none want %h", w);
      else begin
        wr_t g = obs_wr.pop_front();
        if (g !== w) $display("FAIL rescan_write: got %h want %h", g, w); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int c0, e0;
    mem[MASK_A] = 32'h1;
    set_ch(0, 6, 32'h77);
    pulse_cfg();
    wait_run(40, ok);
    obs_arb.delete();
    wready = 1'b0;
    pulse_done(0);
    tick(3);
    n_checks++;
    if (we !== 1'b1) $display("FAIL midwr_pending: got we=%b want 1", we); else n_pass++;
    c0 = chd_cnt;
    e0 = end_cnt;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({rd_en, we, arb_s, arbt, valid, irq_chd, irq_end} !== 7'b0 || active !== 32'h0 || wd !== 32'h0)
      $display("FAIL midwr_reset_outputs: got %b active=%h data=%h want 0 0 0",
               {rd_en, we, arb_s, arbt, valid, irq_chd, irq_end}, active, wd);
    else n_pass++;
    wready = 1'b1;
    tick(2);
    @(negedge clk);
    rstn = 1'b1;
    tick(2);
    n_checks++;
    if (chd_cnt != c0 || end_cnt != e0 || obs_wr.size() != 0)
      $display("FAIL midwr_no_irq: got chd=%0d end=%0d writes=%0d want 0 0 0",
               chd_cnt - c0, end_cnt - e0, obs_wr.size());
    else n_pass++;
    exp_arb.push_back(mk_arb(0, 6, 32'h77));
    pulse_cfg();
    wait_run(40, ok);
    while (exp_arb.size() != 0) begin
      arb_t w = exp_arb.pop_front();
      n_checks++;
      if (obs_arb.size() == 0) $display("FAIL midwr_rescan: got none want %h", w);
      else begin
        arb_t g = obs_arb.pop_front();
        if (g !== w) $display("FAIL midwr_rescan: got %h want %h", g, w); else n_pass++;
      end
    end
    n_checks++;
    if (active !== 32'h1) $display("FAIL midwr_active: got %h want 1", active); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    tick(3);
    test_reset();
    @(negedge clk);
    rstn = 1'b1;
    tick(2);
    test_single();
    test_empty_mask();
    test_stall();
    test_incremental();
    test_rescan();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

endmodule
